// File: rtl/axi_id_serializer_multi_pkg.sv
// Shared types for axi_id_serializer_multi: FSM states and default channel structs.
package axi_id_serializer_multi_pkg;

  typedef enum logic [1:0] {
    Idle,
    Drain,
    Execute
  } state_e;

  localparam int unsigned DefIdWidth = 1;

  // The id field must stay the first (most significant) member of aw/ar/b/r.
  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [31:0]           addr;
    logic [7:0]            len;
    logic [5:0]            atop;
  } def_aw_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [31:0]           addr;
    logic [7:0]            len;
  } def_ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } def_w_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [1:0]            resp;
  } def_b_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [31:0]           data;
    logic [1:0]            resp;
    logic                  last;
  } def_r_t;

  typedef struct packed {
    def_aw_t aw;
    logic    aw_valid;
    def_w_t  w;
    logic    w_valid;
    logic    b_ready;
    def_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } def_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    def_b_t  b;
    logic    b_valid;
    def_r_t  r;
    logic    r_valid;
  } def_resp_t;

endpackage

// File: rtl/axi_pkg.sv
// AXI constants used by the ID serializer: ATOP type field and response-flag bit.
package axi_pkg;

  localparam logic [1:0]  ATOP_NONE        = 2'b00;
  localparam logic [1:0]  ATOP_ATOMICSTORE = 2'b01;
  localparam logic [1:0]  ATOP_ATOMICLOAD  = 2'b10;
  localparam logic [1:0]  ATOP_ATOMICSWAP  = 2'b11;
  localparam int unsigned ATOP_R_RESP      = 32'd5;

endpackage

// File: rtl/axi_id_serializer_multi_queue.sv
// Non-fall-through FIFO holding original slave IDs for one downstream ID.
module axi_id_serializer_multi_queue #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [2**PtrWidth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push, do_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full    = (cnt_q == CntWidth'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push != do_pop) begin
        cnt_q <= do_push ? cnt_q + CntWidth'(1) : cnt_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/axi_id_serializer_multi.sv
// Folds slave IDs onto 2**MstIdWidth master IDs, restoring originals on B/R.
// ATOP isolation is built only with AXI_ID_SERIALIZER_MULTI_ATOP_EN defined.
//   state   | meaning
//   Idle    | normal traffic; an ATOP AW is held back
//   Drain   | AR/AW blocked until all queues empty, then the ATOP AW issues
//   Execute | AR/AW blocked until the ATOP's B (and R) responses drain
module axi_id_serializer_multi
  import axi_pkg::*;
  import axi_id_serializer_multi_pkg::*;
#(
  parameter int unsigned MaxReadTxns  = 1,
  parameter int unsigned MaxWriteTxns = 1,
  parameter int unsigned SlvIdWidth   = 1,
  parameter int unsigned MstIdWidth   = 1,
  parameter type slv_req_t  = def_req_t,
  parameter type slv_resp_t = def_resp_t,
  parameter type mst_req_t  = def_req_t,
  parameter type mst_resp_t = def_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);

  localparam int unsigned NumIds = 2**MstIdWidth;
  localparam int unsigned AwRest = $bits(slv_req_i.aw) - SlvIdWidth;
  localparam int unsigned ArRest = $bits(slv_req_i.ar) - SlvIdWidth;
  localparam int unsigned BRest  = $bits(mst_resp_i.b) - MstIdWidth;
  localparam int unsigned RRest  = $bits(mst_resp_i.r) - MstIdWidth;

  logic [MstIdWidth-1:0] ar_idx, aw_idx, r_idx, b_idx;
  logic [NumIds-1:0]     rd_full, rd_empty, wr_full, wr_empty, rd_pop, wr_pop;
  logic [SlvIdWidth-1:0] rd_head [NumIds];
  logic [SlvIdWidth-1:0] wr_head [NumIds];
  logic [SlvIdWidth-1:0] rd_wdata;
  logic ar_block, aw_block, aw_atop_r;
  logic ar_hs_raw, aw_hs_raw, ar_ok, aw_ok, ar_hs, aw_hs;
  logic r_ok, b_ok, r_pop, b_pop;

  assign ar_idx = slv_req_i.ar.id[MstIdWidth-1:0];
  assign aw_idx = slv_req_i.aw.id[MstIdWidth-1:0];
  assign r_idx  = mst_resp_i.r.id;
  assign b_idx  = mst_resp_i.b.id;

  assign ar_hs_raw = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~rd_full[ar_idx];
  assign aw_hs_raw = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~wr_full[aw_idx];
  assign ar_ok     = ~rd_full[ar_idx] & ~ar_block;
  assign aw_ok     = ~wr_full[aw_idx] & ~aw_block;
  assign ar_hs     = ar_hs_raw & ~ar_block;
  assign aw_hs     = aw_hs_raw & ~aw_block;

  assign r_ok  = ~rd_empty[r_idx];
  assign b_ok  = ~wr_empty[b_idx];
  assign r_pop = mst_resp_i.r_valid & slv_req_i.r_ready & r_ok & mst_resp_i.r.last;
  assign b_pop = mst_resp_i.b_valid & slv_req_i.b_ready & b_ok;

  // AR and an ATOP's read entry never push in the same cycle (AR is blocked then).
  assign rd_wdata = ar_hs ? slv_req_i.ar.id : slv_req_i.aw.id;

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = {aw_idx, slv_req_i.aw[AwRest-1:0]};
`ifndef AXI_ID_SERIALIZER_MULTI_ATOP_EN
    mst_req_o.aw.atop  = '0;
`endif
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready & b_ok;
    mst_req_o.ar       = {ar_idx, slv_req_i.ar[ArRest-1:0]};
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.r_ready  = slv_req_i.r_ready & r_ok;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b        = {wr_head[b_idx], mst_resp_i.b[BRest-1:0]};
    slv_resp_o.b_valid  = mst_resp_i.b_valid & b_ok;
    slv_resp_o.r        = {rd_head[r_idx], mst_resp_i.r[RRest-1:0]};
    slv_resp_o.r_valid  = mst_resp_i.r_valid & r_ok;
  end

  for (genvar i = 0; i < NumIds; i++) begin : gen_queues
    logic rd_push, wr_push;

    assign rd_push   = (ar_hs & (ar_idx == MstIdWidth'(i))) |
                       (aw_hs & aw_atop_r & (aw_idx == MstIdWidth'(i)));
    assign wr_push   = aw_hs & (aw_idx == MstIdWidth'(i));
    assign rd_pop[i] = r_pop & (r_idx == MstIdWidth'(i));
    assign wr_pop[i] = b_pop & (b_idx == MstIdWidth'(i));

    axi_id_serializer_multi_queue #(
      .Depth (MaxReadTxns),
      .Width (SlvIdWidth)
    ) i_rd_queue (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (rd_push),
      .pop   (rd_pop[i]),
      .wdata (rd_wdata),
      .rdata (rd_head[i]),
      .full  (rd_full[i]),
      .empty (rd_empty[i])
    );

    axi_id_serializer_multi_queue #(
      .Depth (MaxWriteTxns),
      .Width (SlvIdWidth)
    ) i_wr_queue (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (wr_push),
      .pop   (wr_pop[i]),
      .wdata (slv_req_i.aw.id),
      .rdata (wr_head[i]),
      .full  (wr_full[i]),
      .empty (wr_empty[i])
    );
  end

`ifdef AXI_ID_SERIALIZER_MULTI_ATOP_EN
  state_e state_q, state_d;
  logic   aw_is_atop, all_empty, drained;

  assign aw_is_atop = (slv_req_i.aw.atop[5:4] != ATOP_NONE);
  assign aw_atop_r  = aw_is_atop & slv_req_i.aw.atop[ATOP_R_RESP];
  assign all_empty  = &{rd_empty, wr_empty};
  // In Execute only the ATOP's own entries remain, so one pop empties a queue.
  assign drained    = &{rd_empty | rd_pop, wr_empty | wr_pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ar_block = 1'b0;
    aw_block = 1'b0;
    case (state_q)
      Idle: begin
        aw_block = aw_is_atop;
        if (slv_req_i.aw_valid && aw_is_atop && (!slv_req_i.ar_valid || ar_hs_raw)) begin
          state_d = Drain;
        end
      end
      Drain: begin
        ar_block = 1'b1;
        aw_block = ~all_empty;
        if (aw_hs_raw && all_empty) state_d = Execute;
      end
      Execute: begin
        if (drained) begin
          state_d  = Idle;
          aw_block = aw_is_atop;
        end else begin
          ar_block = 1'b1;
          aw_block = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end
`else
  assign ar_block  = 1'b0;
  assign aw_block  = 1'b0;
  assign aw_atop_r = 1'b0;
`endif

endmodule

// File: tb/tb_axi_id_serializer_multi.sv
// Directed bench for axi_id_serializer_multi (SlvIdWidth 4, MstIdWidth 2, depth 2).
module tb_axi_id_serializer_multi;

  typedef struct packed {
    logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [5:0] atop;
  } s_aw_t;
  typedef struct packed {
    logic [1:0] id; logic [31:0] addr; logic [7:0] len; logic [5:0] atop;
  } m_aw_t;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } s_ar_t;
  typedef struct packed { logic [1:0] id; logic [31:0] addr; logic [7:0] len; } m_ar_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } s_b_t;
  typedef struct packed { logic [1:0] id; logic [1:0] resp; } m_b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } s_r_t;
  typedef struct packed { logic [1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } m_r_t;

  typedef struct packed {
    s_aw_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    s_ar_t ar; logic ar_valid; logic r_ready;
  } s_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; s_b_t b; logic b_valid; s_r_t r; logic r_valid;
  } s_resp_t;
  typedef struct packed {
    m_aw_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    m_ar_t ar; logic ar_valid; logic r_ready;
  } m_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; m_b_t b; logic b_valid; m_r_t r; logic r_valid;
  } m_resp_t;

  typedef struct {
    int arv, arid, arrdy, rv, rid, rlast, rrdy;
    int e_mav, e_maid, e_sardy, e_srv, e_srid, e_mrr;
  } vec_t;

  logic    clk, rst;
  s_req_t  slv_req;
  s_resp_t slv_resp;
  m_req_t  mst_req;
  m_resp_t mst_resp;
  int      n_chk, n_pass;
  vec_t    vt [17];

  axi_id_serializer_multi #(
    .MaxReadTxns  (2),
    .MaxWriteTxns (2),
    .SlvIdWidth   (4),
    .MstIdWidth   (2),
    .slv_req_t    (s_req_t),
    .slv_resp_t   (s_resp_t),
    .mst_req_t    (m_req_t),
    .mst_resp_t   (m_resp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    slv_req  = '0;
    mst_resp = '0;
    slv_req.b_ready     = 1'b1;
    slv_req.r_ready     = 1'b1;
    mst_resp.ar_ready   = 1'b1;
    mst_resp.aw_ready   = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    // arv arid arrdy | rv rid rlast rrdy | e_mav e_maid e_sardy | e_srv e_srid e_mrr
    vt[0]  = '{0, 0,   1, 1, 1, 1, 1, 0, 0, 1, 0, 0,   0};
    vt[1]  = '{1, 5,   1, 0, 0, 0, 0, 1, 1, 1, 0, 0,   0};
    vt[2]  = '{1, 9,   1, 0, 0, 0, 0, 1, 1, 1, 0, 0,   0};
    vt[3]  = '{1, 'hD, 1, 1, 1, 1, 0, 0, 1, 0, 1, 5,   0};
    vt[4]  = '{1, 'hD, 1, 1, 1, 1, 1, 0, 1, 0, 1, 5,   1};
    vt[5]  = '{0, 0,   1, 1, 1, 1, 1, 0, 0, 1, 1, 9,   1};
    vt[6]  = '{1, 1,   1, 0, 0, 0, 0, 1, 1, 1, 0, 0,   0};
    vt[7]  = '{1, 2,   1, 0, 0, 0, 0, 1, 2, 1, 0, 0,   0};
    vt[8]  = '{0, 0,   1, 1, 2, 1, 1, 0, 0, 1, 1, 2,   1};
    vt[9]  = '{0, 0,   1, 1, 1, 1, 1, 0, 0, 1, 1, 1,   1};
    vt[10] = '{0, 0,   1, 1, 1, 1, 1, 0, 0, 1, 0, 0,   0};
    vt[11] = '{1, 6,   1, 0, 0, 0, 0, 1, 2, 1, 0, 0,   0};
    vt[12] = '{1, 'hA, 1, 1, 2, 1, 1, 1, 2, 1, 1, 6,   1};
    vt[13] = '{0, 0,   1, 1, 2, 1, 1, 0, 0, 1, 1, 'hA, 1};
    vt[14] = '{0, 0,   1, 1, 2, 1, 1, 0, 0, 1, 0, 0,   0};
    vt[15] = '{1, 3,   0, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0};
    vt[16] = '{0, 0,   1, 1, 3, 1, 1, 0, 0, 1, 0, 0,   0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state: responses blocked, AR passes with mapped ID
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd1; mst_resp.r.last = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd0;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'h5;
    slv_req.w_valid  = 1'b1; slv_req.w.data = 32'hDEADBEEF; mst_resp.w_ready = 1'b1;
    settle();
    chk("rst slv_r_valid", 32'(slv_resp.r_valid), 0);
    chk("rst slv_b_valid", 32'(slv_resp.b_valid), 0);
    chk("rst mst_r_ready", 32'(mst_req.r_ready), 0);
    chk("rst mst_b_ready", 32'(mst_req.b_ready), 0);
    chk("rst mst_ar_valid", 32'(mst_req.ar_valid), 1);
    chk("rst mst_ar_id", 32'(mst_req.ar.id), 1);
    chk("w data pass", mst_req.w.data, 'hDEADBEEF);
    chk("w_ready pass", 32'(slv_resp.w_ready), 1);
    idle_inputs();
    tick();

    for (int i = 0; i < 17; i++) begin
      idle_inputs();
      slv_req.ar_valid   = vt[i].arv[0];
      slv_req.ar.id      = 4'(vt[i].arid);
      mst_resp.ar_ready  = vt[i].arrdy[0];
      mst_resp.r_valid   = vt[i].rv[0];
      mst_resp.r.id      = 2'(vt[i].rid);
      mst_resp.r.last    = vt[i].rlast[0];
      slv_req.r_ready    = vt[i].rrdy[0];
      settle();
      chk($sformatf("row%0d mst_ar_valid", i), 32'(mst_req.ar_valid), vt[i].e_mav);
      if (vt[i].e_mav != 0)
        chk($sformatf("row%0d mst_ar_id", i), 32'(mst_req.ar.id), vt[i].e_maid);
      chk($sformatf("row%0d slv_ar_ready", i), 32'(slv_resp.ar_ready), vt[i].e_sardy);
      chk($sformatf("row%0d slv_r_valid", i), 32'(slv_resp.r_valid), vt[i].e_srv);
      if (vt[i].e_srv != 0)
        chk($sformatf("row%0d slv_r_id", i), 32'(slv_resp.r.id), vt[i].e_srid);
      chk($sformatf("row%0d mst_r_ready", i), 32'(mst_req.r_ready), vt[i].e_mrr);
      tick();
    end

    // full write queue: third AW on mapped id 0 waits for the first B
    idle_inputs();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'h0;
    settle();
    chk("fq aw0 ready", 32'(slv_resp.aw_ready), 1);
    tick();
    slv_req.aw.id = 4'h4;
    settle();
    chk("fq aw4 ready", 32'(slv_resp.aw_ready), 1);
    chk("fq aw4 mst id", 32'(mst_req.aw.id), 0);
    tick();
    slv_req.aw.id = 4'h8;
    settle();
    chk("fq aw8 ready", 32'(slv_resp.aw_ready), 0);
    chk("fq aw8 mst valid", 32'(mst_req.aw_valid), 0);
    tick();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd0;
    settle();
    chk("fq b0 valid", 32'(slv_resp.b_valid), 1);
    chk("fq b0 id", 32'(slv_resp.b.id), 'h0);
    chk("fq aw8 ready on pop", 32'(slv_resp.aw_ready), 0);
    tick();
    mst_resp.b_valid = 1'b0;
    settle();
    chk("fq aw8 ready after pop", 32'(slv_resp.aw_ready), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    settle();
    chk("fq b id 4", 32'(slv_resp.b.id), 'h4);
    tick();
    settle();
    chk("fq b id 8", 32'(slv_resp.b.id), 'h8);
    tick();
    settle();
    chk("fq b empty", 32'(slv_resp.b_valid), 0);
    idle_inputs();
    tick();

`ifdef AXI_ID_SERIALIZER_MULTI_ATOP_EN
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'h1;
    tick();
    idle_inputs();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'h6; slv_req.aw.atop = 6'h20;
    settle();
    chk("atop idle aw held", 32'(mst_req.aw_valid), 0);
    chk("atop idle aw_ready", 32'(slv_resp.aw_ready), 0);
    tick();
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'h3;
    settle();
    chk("atop drain ar blocked", 32'(mst_req.ar_valid), 0);
    chk("atop drain aw held", 32'(mst_req.aw_valid), 0);
    tick();
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd1; mst_resp.r.last = 1'b1;
    settle();
    chk("atop drain r id", 32'(slv_resp.r.id), 'h1);
    chk("atop aw held on last r", 32'(mst_req.aw_valid), 0);
    tick();
    mst_resp.r_valid = 1'b0;
    settle();
    chk("atop aw issued", 32'(mst_req.aw_valid), 1);
    chk("atop aw id", 32'(mst_req.aw.id), 2);
    chk("atop aw atop", 32'(mst_req.aw.atop), 'h20);
    chk("atop ar still blocked", 32'(mst_req.ar_valid), 0);
    tick();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd2;
    settle();
    chk("atop b id", 32'(slv_resp.b.id), 'h6);
    chk("atop ar blocked on b", 32'(mst_req.ar_valid), 0);
    tick();
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd2; mst_resp.r.last = 1'b1;
    settle();
    chk("atop r id", 32'(slv_resp.r.id), 'h6);
    chk("atop ar released", 32'(mst_req.ar_valid), 1);
    chk("atop ar mst id", 32'(mst_req.ar.id), 3);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp.r.id = 2'd3;
    settle();
    chk("atop after ar r id", 32'(slv_resp.r.id), 'h3);
    tick();
    idle_inputs();
`else
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'h6; slv_req.aw.atop = 6'h20;
    settle();
    chk("noatop aw valid", 32'(mst_req.aw_valid), 1);
    chk("noatop aw id", 32'(mst_req.aw.id), 2);
    chk("noatop aw atop", 32'(mst_req.aw.atop), 0);
    chk("noatop aw ready", 32'(slv_resp.aw_ready), 1);
    tick();
    idle_inputs();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd2;
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd2; mst_resp.r.last = 1'b1;
    settle();
    chk("noatop b valid", 32'(slv_resp.b_valid), 1);
    chk("noatop b id", 32'(slv_resp.b.id), 'h6);
    chk("noatop no r entry", 32'(slv_resp.r_valid), 0);
    tick();
    idle_inputs();
`endif

    // mid-operation reset with three entries outstanding
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'h1;
    tick();
    slv_req.ar.id = 4'h2;
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'h0;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd0;
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd1; mst_resp.r.last = 1'b1;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'h2;
    settle();
    chk("mrst slv_b_valid", 32'(slv_resp.b_valid), 0);
    chk("mrst mst_b_ready", 32'(mst_req.b_ready), 0);
    chk("mrst slv_r_valid", 32'(slv_resp.r_valid), 0);
    chk("mrst mst_r_ready", 32'(mst_req.r_ready), 0);
    chk("mrst ar passes", 32'(mst_req.ar_valid), 1);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
